// File: rtl/router_fifo_pkt.sv
// Packet-aware output FIFO for one router channel: stores {lfd, data} words,
// tracks packet boundaries on both sides and flags the parity byte on read.
module router_fifo_pkt #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     lfd_state,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     read_enb,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     last_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = DATA_WIDTH - 2;
    localparam int RW = LW + 1;

    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         pkt_count_q, pkt_count_d;
    logic [RW-1:0]         wr_rem_q, wr_rem_d;
    logic [RW-1:0]         rd_rem_q, rd_rem_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q, last_out_q, overflow_q;

    logic                  wr_acc, rd_acc, wr_done, rd_last, flush;
    logic [DATA_WIDTH:0]   rd_word;
    logic [RW-1:0]         wr_len_p1, rd_len_p1;

    assign flush       = reset || soft_reset;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AFULL_LEVEL));
    assign wr_acc      = write_enb && !full;
    assign rd_acc      = read_enb && !empty;
    assign rd_word     = mem_q[rd_ptr_q];
    assign wr_len_p1   = RW'(data_in[DATA_WIDTH-1:2]) + RW'(1);
    assign rd_len_p1   = RW'(rd_word[DATA_WIDTH-1:2]) + RW'(1);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_rem_d = wr_rem_q;
        wr_done  = 1'b0;
        if (wr_acc) begin
            if (lfd_state) begin
                wr_rem_d = wr_len_p1;
            end else if (wr_rem_q != '0) begin
                wr_rem_d = wr_rem_q - RW'(1);
                wr_done  = (wr_rem_q == RW'(1));
            end
        end

        rd_rem_d = rd_rem_q;
        rd_last  = 1'b0;
        if (rd_acc) begin
            if (rd_word[DATA_WIDTH]) begin
                rd_rem_d = rd_len_p1;
            end else if (rd_rem_q != '0) begin
                rd_rem_d = rd_rem_q - RW'(1);
                rd_last  = (rd_rem_q == RW'(1));
            end
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({wr_done, rd_last})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_count_q  <= '0;
            wr_rem_q     <= '0;
            rd_rem_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            last_out_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                data_out_q <= rd_word[DATA_WIDTH-1:0];
            end
            count_q      <= count_d;
            pkt_count_q  <= pkt_count_d;
            wr_rem_q     <= wr_rem_d;
            rd_rem_q     <= rd_rem_d;
            data_valid_q <= rd_acc;
            last_out_q   <= rd_last;
            overflow_q   <= write_enb && full;
        end
    end

    // NOTE: storage has no reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clock) begin
        if (wr_acc && !flush) mem_q[wr_ptr_q] <= {lfd_state, data_in};
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign last_out   = last_out_q;
    assign count      = count_q;
    assign pkt_count  = pkt_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Self-checking bench for router_fifo_pkt: directed vector table, scripted
// corner sequences and randomized traffic against a queue-based model.
module tb_router_fifo_pkt;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, last_out, full, empty, almost_full, overflow;
    logic [4:0] count, pkt_count;

    router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(14)) dut (
        .clock       (clock),
        .reset       (reset),
        .soft_reset  (soft_reset),
        .write_enb   (write_enb),
        .lfd_state   (lfd_state),
        .data_in     (data_in),
        .read_enb    (read_enb),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .last_out    (last_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .pkt_count   (pkt_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a queue of stored {lfd, data} entries plus packet counters.
    logic [8:0] mq[$];
    int         m_wr_rem = 0, m_rd_rem = 0, m_pkt = 0;
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0, m_last = 1'b0, m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_update();
        bit mfull, mempty, wacc, racc, done, lastv;
        logic [8:0] e;
        if (reset || soft_reset) begin
            mq.delete();
            m_wr_rem = 0; m_rd_rem = 0; m_pkt = 0;
            m_dout = 8'h00; m_dv = 1'b0; m_last = 1'b0; m_ovf = 1'b0;
            return;
        end
        mfull  = (mq.size() == 16);
        mempty = (mq.size() == 0);
        wacc   = write_enb && !mfull;
        racc   = read_enb && !mempty;
        m_ovf  = write_enb && mfull;
        done   = 1'b0;
        lastv  = 1'b0;
        if (racc) begin
            e = mq.pop_front();
            m_dout = e[7:0];
            m_dv = 1'b1;
            if (e[8]) m_rd_rem = int'(e[7:2]) + 1;
            else if (m_rd_rem > 0) begin
                m_rd_rem--;
                lastv = (m_rd_rem == 0);
            end
        end else begin
            m_dv = 1'b0;
        end
        m_last = lastv;
        if (wacc) begin
            mq.push_back({lfd_state, data_in});
            if (lfd_state) m_wr_rem = int'(data_in[7:2]) + 1;
            else if (m_wr_rem > 0) begin
                m_wr_rem--;
                done = (m_wr_rem == 0);
            end
        end
        m_pkt = m_pkt + int'(done) - int'(lastv);
    endtask

    task automatic compare_all();
        check("data_out",    data_out,    m_dout);
        check("data_valid",  data_valid,  m_dv);
        check("last_out",    last_out,    m_last);
        check("count",       count,       mq.size());
        check("pkt_count",   pkt_count,   m_pkt);
        check("full",        full,        mq.size() == 16);
        check("empty",       empty,       mq.size() == 0);
        check("almost_full", almost_full, mq.size() >= 14);
        check("overflow",    overflow,    m_ovf);
    endtask

    task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                        input logic re, input logic sr);
        @(negedge clock);
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = sr;
        @(posedge clock);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       we, lfd;
        logic [7:0] din;
        logic       re;
        int         e_count, e_pkt;
        logic [7:0] e_dout;
        logic       e_dv, e_last;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'h05, 1'b0, 1, 0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'hAA, 1'b0, 2, 0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h5C, 1'b0, 3, 1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1, 8'h05, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1, 8'hAA, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 0, 8'h5C, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 0, 8'h5C, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h01, 1'b1, 1, 0, 8'h5C, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 8'h77, 1'b1, 1, 1, 8'h01, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 0, 8'h77, 1'b1, 1'b1};

        do_reset();
        check("rst_data_out", data_out, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_count", count, 5'd0);

        // Directed vector table: short packet, empty read, simultaneous access.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].we, vecs[i].lfd, vecs[i].din, vecs[i].re, 1'b0);
            check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            check($sformatf("vec%0d_pkt", i), pkt_count, vecs[i].e_pkt);
            check($sformatf("vec%0d_dout", i), data_out, vecs[i].e_dout);
            check($sformatf("vec%0d_dv", i), data_valid, vecs[i].e_dv);
            check($sformatf("vec%0d_last", i), last_out, vecs[i].e_last);
        end

        // len=9 packet: header, 9 payload bytes, parity.
        step(1'b1, 1'b1, 8'h25, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        check("pkt9_count", count, 5'd11);
        check("pkt9_pkt", pkt_count, 5'd1);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("pkt9_last", last_out, 1'b1);
        check("pkt9_dout", data_out, 8'h3C);
        check("pkt9_empty", empty, 1'b1);
        check("pkt9_pkt0", pkt_count, 5'd0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
            if (i == 12) check("afull_13", almost_full, 1'b0);
            if (i == 13) check("afull_14", almost_full, 1'b1);
            if (i == 14) check("full_15", full, 1'b0);
        end
        check("full_16", full, 1'b1);
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        check("ovf_pulse", overflow, 1'b1);
        check("ovf_count", count, 5'd16);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_gone", overflow, 1'b0);

        // Full with read+write: write rejected.
        step(1'b1, 1'b0, 8'hEF, 1'b1, 1'b0);
        check("fullrw_count", count, 5'd15);
        check("fullrw_dout", data_out, 8'h80);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("cnt8", count, 5'd8);
        step(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
        check("rw8_count", count, 5'd8);
        check("rw8_dout", data_out, 8'h88);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rw8_tail", data_out, 8'h55);

        // Back-to-back packets (len=2, len=0) with continuous reads across wrap.
        begin
            logic [8:0] seq[6];
            int lasts = 0;
            seq = '{9'h109, 9'h0A1, 9'h0A2, 9'h0C3, 9'h101, 9'h0C4};
            for (int i = 0; i < 9; i++) begin
                if (i < 6) step(1'b1, seq[i][8], seq[i][7:0], 1'b1, 1'b0);
                else       step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
                check("b2b_pkt_le2", pkt_count <= 5'd2, 1'b1);
                if (last_out) lasts++;
            end
            check("b2b_lasts", lasts, 2);
            check("b2b_empty", empty, 1'b1);
        end

        // Soft reset mid-packet with write_enb high.
        step(1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        check("srst_empty", empty, 1'b1);
        check("srst_count", count, 5'd0);
        check("srst_pkt", pkt_count, 5'd0);
        check("srst_dv", data_valid, 1'b0);
        check("srst_dout", data_out, 8'h00);
        step(1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h32, 1'b0, 1'b0);
        check("srst_new_pkt", pkt_count, 5'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("srst_new_last", last_out, 1'b1);
        check("srst_new_dout", data_out, 8'h32);

        // Abandoned header: only the second packet completes.
        step(1'b1, 1'b1, 8'h15, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h43, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        check("abandon_pkt", pkt_count, 5'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("abandon_last", last_out, 1'b1);
        check("abandon_pkt0", pkt_count, 5'd0);

        // Randomized traffic in phases of varying read pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int rd_pct = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 60 : 90);
            for (int i = 0; i < 500; i++) begin
                logic       we, re, lfd, sr;
                logic [7:0] din;
                we  = ($urandom_range(0, 99) < 70);
                re  = ($urandom_range(0, 99) < rd_pct);
                lfd = ($urandom_range(0, 7) == 0);
                din = lfd ? {6'($urandom_range(0, 5)), 2'($urandom_range(0, 2))}
                          : 8'($urandom);
                sr  = ($urandom_range(0, 249) == 0);
                step(we, lfd, din, re, sr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
